regfile_mp: RTL and testbench

- Parametrised multi-port register file for the 24-bit core. Successor to the single-write-port register file.
- Provides two combinational read ports and two write ports: port A for ALU writeback, port B for load writeback.
- Adds a per-register pending scoreboard for hazard detection, optional same-cycle write-to-read bypass, and a sequenced bulk re-initialise operation.
- Sits in the decode stage; the writeback stage and issue logic drive it.

---
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending scoreboard, optional
// same-cycle write bypass and a sequenced bulk re-initialise.
module regfile_mp #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW = $clog2(DEPTH),
  parameter bit BYPASS = 1'b1,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VEC = (DEPTH*WIDTH)'({24'h04FEFF, 24'h04BDF0,
                                                   24'h050000, 24'h025F78,
                                                   24'h000100, 24'h000000})
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr_1,
  output logic [WIDTH-1:0] rd_data_1,
  output logic             rd_pend_1,
  input  logic [AW-1:0]    rd_addr_2,
  output logic [WIDTH-1:0] rd_data_2,
  output logic             rd_pend_2,
  input  logic             wr_en_a,
  input  logic [AW-1:0]    wr_addr_a,
  input  logic [WIDTH-1:0] wr_data_a,
  input  logic             wr_en_b,
  input  logic [AW-1:0]    wr_addr_b,
  input  logic [WIDTH-1:0] wr_data_b,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             wr_conflict
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             clr_busy_d, clr_done_d, wr_conflict_d;
  logic             port_en, byp_en, we_a, we_b, iss_v;

  // Port qualification: ports are frozen while the sequenced clear owns the array;
  // register 0 is hard-wired so writes/issues to it are discarded.
  assign port_en = (state_q != S_CLEAR);
  assign byp_en  = BYPASS && (state_q == S_IDLE);
  assign we_a    = wr_en_a && port_en && (wr_addr_a != '0);
  assign we_b    = wr_en_b && port_en && (wr_addr_b != '0);
  assign iss_v   = iss_en  && port_en && (iss_addr  != '0);

  // Clear sequencer next-state, counter and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_busy_d    = 1'b0;
    clr_done_d    = 1'b0;
    wr_conflict_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    clr_busy_d    = (state_d == S_CLEAR);
    clr_done_d    = (state_d == S_DONE);
    wr_conflict_d = we_a && we_b && (wr_addr_a == wr_addr_b);
  end

  // Sequencer state, counter and status output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_busy    <= clr_busy_d;
      clr_done    <= clr_done_d;
      wr_conflict <= wr_conflict_d;
    end
  end

  // Register array: reset/clear restore the init vector; port B written last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VEC[i*WIDTH +: WIDTH];
      end
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= RESET_VEC[32'(cnt_q)*WIDTH +: WIDTH];
    end else begin
      if (we_a) mem_q[wr_addr_a] <= wr_data_a;
      if (we_b) mem_q[wr_addr_b] <= wr_data_b;
    end
  end

  // Pending scoreboard: writes retire a producer, a same-cycle issue overrides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (state_q == S_CLEAR) begin
      pend_q[cnt_q] <= 1'b0;
    end else begin
      if (we_a)  pend_q[wr_addr_a] <= 1'b0;
      if (we_b)  pend_q[wr_addr_b] <= 1'b0;
      if (iss_v) pend_q[iss_addr]  <= 1'b1;
    end
  end

  // Read port 1: stored value, overridden by same-cycle write data when bypassing.
  always_comb begin
    rd_data_1 = mem_q[rd_addr_1];
    if (byp_en && we_a && (wr_addr_a == rd_addr_1)) rd_data_1 = wr_data_a;
    if (byp_en && we_b && (wr_addr_b == rd_addr_1)) rd_data_1 = wr_data_b;
    if (rd_addr_1 == '0) rd_data_1 = '0;
    rd_pend_1 = pend_q[rd_addr_1] && (rd_addr_1 != '0);
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd_data_2 = mem_q[rd_addr_2];
    if (byp_en && we_a && (wr_addr_a == rd_addr_2)) rd_data_2 = wr_data_a;
    if (byp_en && we_b && (wr_addr_b == rd_addr_2)) rd_data_2 = wr_data_b;
    if (rd_addr_2 == '0) rd_data_2 = '0;
    rd_pend_2 = pend_q[rd_addr_2] && (rd_addr_2 != '0);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic against
// an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [AW-1:0]    rd_addr_1, rd_addr_2, wr_addr_a, wr_addr_b, iss_addr;
  logic [WIDTH-1:0] wr_data_a, wr_data_b;
  logic             wr_en_a, wr_en_b, iss_en, clr_req;
  logic [WIDTH-1:0] rd_data_1, rd_data_2, nb_rd_data_1, nb_rd_data_2;
  logic             rd_pend_1, rd_pend_2, nb_rd_pend_1, nb_rd_pend_2;
  logic             clr_busy, clr_done, wr_conflict;
  logic             nb_clr_busy, nb_clr_done, nb_wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [WIDTH-1:0] rv    [DEPTH];
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_pend[DEPTH];
  bit               m_busy;
  bit               m_conf;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_pend_1(rd_pend_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_pend_2(rd_pend_2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_1(rd_addr_1), .rd_data_1(nb_rd_data_1), .rd_pend_1(nb_rd_pend_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(nb_rd_data_2), .rd_pend_2(nb_rd_pend_2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req),
    .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .wr_conflict(nb_wr_conflict)
  );

  function automatic logic [WIDTH-1:0] exp_read(input logic [AW-1:0] addr, input bit byp);
    if (addr == '0) return '0;
    if (byp && wr_en_b && wr_addr_b == addr) return wr_data_b;
    if (byp && wr_en_a && wr_addr_a == addr) return wr_data_a;
    return m_mem[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i]  = rv[i];
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_conf = 1'b0;
  endtask

  // Apply what the array should absorb on the edge just taken.
  task automatic model_commit();
    m_conf = 1'b0;
    if (!m_busy) begin
      if (wr_en_a && wr_addr_a != '0) m_mem[wr_addr_a] = wr_data_a;
      if (wr_en_b && wr_addr_b != '0) m_mem[wr_addr_b] = wr_data_b;
      if (wr_en_a) m_pend[wr_addr_a] = 1'b0;
      if (wr_en_b) m_pend[wr_addr_b] = 1'b0;
      if (iss_en && iss_addr != '0) m_pend[iss_addr] = 1'b1;
      m_conf = wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b) && (wr_addr_a != '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_a = 1'b0; wr_en_b = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; iss_addr = '0;
    wr_data_a = '0; wr_data_b = '0;
  endtask

  // Sweep every register and pending bit through read port 1 (inputs idle).
  task automatic sweep(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_addr_1 = AW'(a);
      #1;
      n_checks++;
      if (rd_data_1 !== m_mem[a] || rd_pend_1 !== (a != 0 && m_pend[a])) begin
        n_fail++;
        $display("FAIL %s reg%0d: got data=%h pend=%b, expected data=%h pend=%b",
                 tag, a, rd_data_1, rd_pend_1, m_mem[a], (a != 0 && m_pend[a]));
      end
    end
  endtask

  task automatic fill_all();
    for (int a = 1; a < int'(DEPTH); a++) begin
      wr_en_a = 1'b1; wr_addr_a = AW'(a); wr_data_a = 24'hFFFFFF;
      iss_en  = 1'b1; iss_addr  = AW'(a);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rd_addr_1 = 4'd2; rd_addr_2 = 4'd3;
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h025F78 || rd_data_2 !== 24'h050000) begin
      n_fail++;
      $display("FAIL reset_read: got %h/%h, expected 025f78/050000", rd_data_1, rd_data_2);
    end
    n_checks++;
    if (rd_pend_1 !== 1'b0 || rd_pend_2 !== 1'b0 || clr_busy !== 1'b0 ||
        clr_done !== 1'b0 || wr_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: pend=%b%b busy=%b done=%b conf=%b, expected all 0",
               rd_pend_1, rd_pend_2, clr_busy, clr_done, wr_conflict);
    end
    sweep("reset_sweep");
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] old;
    old = m_mem[7];
    wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 24'h123456; rd_addr_1 = 4'd7;
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h123456) begin
      n_fail++;
      $display("FAIL bypass_on: got %h, expected 123456", rd_data_1);
    end
    n_checks++;
    if (nb_rd_data_1 !== old) begin
      n_fail++;
      $display("FAIL bypass_off_same_cycle: got %h, expected %h", nb_rd_data_1, old);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h123456 || nb_rd_data_1 !== 24'h123456) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: got %h/%h, expected 123456", rd_data_1, nb_rd_data_1);
    end
  endtask

  task automatic test_conflict();
    wr_en_a = 1'b1; wr_addr_a = 4'd9; wr_data_a = 24'h000AAA;
    wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 24'h000BBB;
    rd_addr_1 = 4'd9;
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h000BBB) begin
      n_fail++;
      $display("FAIL conflict_bypass_b: got %h, expected 000bbb", rd_data_1);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h000BBB || wr_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_commit: data=%h conf=%b, expected 000bbb/1", rd_data_1, wr_conflict);
    end
    tick();
    n_checks++;
    if (wr_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_one_cycle: got %b, expected 0", wr_conflict);
    end
    wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 24'h000AAA;
    wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = 24'h000BBB;
    rd_addr_1 = 4'd0;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_data_1 !== 24'h0 || wr_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_reg0: data=%h conf=%b, expected 0/0", rd_data_1, wr_conflict);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr_1 = 4'd5; rd_addr_2 = 4'd0;
    iss_en = 1'b1; iss_addr = 4'd5;
    #1;
    n_checks++;
    if (rd_pend_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_no_bypass: got %b, expected 0", rd_pend_1);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_pend_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_set: got %b, expected 1", rd_pend_1);
    end
    iss_en = 1'b1; iss_addr = 4'd5;
    wr_en_b = 1'b1; wr_addr_b = 4'd5; wr_data_b = 24'h00C0DE;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_pend_1 !== 1'b1 || rd_data_1 !== 24'h00C0DE) begin
      n_fail++;
      $display("FAIL pend_set_wins: pend=%b data=%h, expected 1/00c0de", rd_pend_1, rd_data_1);
    end
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 24'h000055;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_pend_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_clear: got %b, expected 0", rd_pend_1);
    end
    iss_en = 1'b1; iss_addr = 4'd0;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_pend_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_reg0: got %b, expected 0", rd_pend_2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_en_a   = 1'($urandom);
      wr_addr_a = AW'($urandom_range(0, DEPTH - 1));
      wr_data_a = WIDTH'($urandom);
      wr_en_b   = 1'($urandom);
      wr_addr_b = AW'($urandom_range(0, DEPTH - 1));
      wr_data_b = WIDTH'($urandom);
      iss_en    = 1'($urandom);
      iss_addr  = AW'($urandom_range(0, DEPTH - 1));
      rd_addr_1 = AW'($urandom_range(0, DEPTH - 1));
      rd_addr_2 = (c % 5 == 0) ? wr_addr_b : AW'($urandom_range(0, DEPTH - 1));
      #1;
      n_checks++;
      if (rd_data_1 !== exp_read(rd_addr_1, 1'b1) || rd_data_2 !== exp_read(rd_addr_2, 1'b1) ||
          nb_rd_data_1 !== exp_read(rd_addr_1, 1'b0)) begin
        n_fail++;
        $display("FAIL rand_read c=%0d: got %h/%h/%h, expected %h/%h/%h", c,
                 rd_data_1, rd_data_2, nb_rd_data_1, exp_read(rd_addr_1, 1'b1),
                 exp_read(rd_addr_2, 1'b1), exp_read(rd_addr_1, 1'b0));
      end
      n_checks++;
      if (rd_pend_1 !== m_pend[rd_addr_1] || rd_pend_2 !== m_pend[rd_addr_2]) begin
        n_fail++;
        $display("FAIL rand_pend c=%0d: got %b%b, expected %b%b", c, rd_pend_1, rd_pend_2,
                 m_pend[rd_addr_1], m_pend[rd_addr_2]);
      end
      tick();
      n_checks++;
      if (wr_conflict !== m_conf) begin
        n_fail++;
        $display("FAIL rand_conflict c=%0d: got %b, expected %b", c, wr_conflict, m_conf);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cycles;
    int k;
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    m_busy = 1'b1;
    busy_cycles = 0;
    k = 0;
    while (clr_busy === 1'b1 && busy_cycles < 100) begin
      wr_en_a   = 1'($urandom);
      wr_addr_a = AW'($urandom_range(0, DEPTH - 1));
      wr_data_a = WIDTH'($urandom);
      wr_en_b   = 1'($urandom);
      wr_addr_b = wr_addr_a;
      wr_data_b = WIDTH'($urandom);
      iss_en    = 1'b1;
      iss_addr  = AW'($urandom_range(1, DEPTH - 1));
      clr_req   = 1'($urandom);
      rd_addr_1 = wr_addr_a;
      rd_addr_2 = AW'($urandom_range(0, DEPTH - 1));
      #1;
      n_checks++;
      if (rd_data_1 !== exp_read(rd_addr_1, 1'b0) || rd_data_2 !== exp_read(rd_addr_2, 1'b0) ||
          rd_pend_2 !== m_pend[rd_addr_2] || clr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_read k=%0d: got %h/%h pend=%b done=%b, expected %h/%h pend=%b done=0",
                 k, rd_data_1, rd_data_2, rd_pend_2, clr_done, exp_read(rd_addr_1, 1'b0),
                 exp_read(rd_addr_2, 1'b0), m_pend[rd_addr_2]);
      end
      tick();
      if (k < int'(DEPTH)) begin
        m_mem[k]  = rv[k];
        m_pend[k] = 1'b0;
      end
      k++;
      busy_cycles++;
      n_checks++;
      if (wr_conflict !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_conflict k=%0d: got %b, expected 0", k, wr_conflict);
      end
    end
    idle_inputs();
    m_busy = 1'b0;
    n_checks++;
    if (busy_cycles != int'(DEPTH)) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d cycles, expected %0d", busy_cycles, DEPTH);
    end
    n_checks++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done_pulse: done=%b busy=%b, expected 1/0", clr_done, clr_busy);
    end
    tick();
    n_checks++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done_once: done=%b busy=%b, expected 0/0", clr_done, clr_busy);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (m_mem[a] !== rv[a]) $display("model note reg%0d not restored", a);
    end
    sweep("clear_final");
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    m_busy = 1'b1;
    repeat (6) tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_status: busy=%b done=%b, expected 0/0", clr_busy, clr_done);
    end
    sweep("midclear_regs");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      n_checks++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midclear_no_done c=%0d: done=%b busy=%b, expected 0/0", c, clr_done, clr_busy);
      end
    end
  endtask

  initial begin
    rv = '{24'h000000, 24'h000100, 24'h025F78, 24'h050000, 24'h04BDF0, 24'h04FEFF,
           24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    model_reset();
    idle_inputs();
    rd_addr_1 = '0;
    rd_addr_2 = '0;
    rst = 1'b0;
    #12;
    rst = 1'b1;
    test_reset();
    tick();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
